reg_file_bypass: RTL and testbench

Parametrised multi-read, dual-write register file for the pipelined RISC-V core. It replaces the negedge-write register file with a single-edge (posedge) design plus same-cycle write-to-read bypass. It adds an asynchronous clear and a per-register busy scoreboard used by the hazard unit for load-use and long-latency stalls. It sits in the decode stage: read ports feed the ID/EX register, write ports come from writeback, and busy-set comes from issue.

---
 rtl/reg_file_bypass.sv | 84 ++++++++
 tb/tb_reg_file_bypass.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_file_bypass.sv
// Multi-read, dual-write register file with same-cycle write-to-read bypass
// and a per-register busy scoreboard for the hazard unit.
module reg_file_bypass #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     we0,
  input  logic [ADDR_W-1:0]        wa0,
  input  logic [DATA_W-1:0]        wd0,
  input  logic                     we1,
  input  logic [ADDR_W-1:0]        wa1,
  input  logic [DATA_W-1:0]        wd1,
  input  logic                     busy_set,
  input  logic [ADDR_W-1:0]        busy_addr
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  busy;
  logic [DEPTH-1:0]  busy_nxt;
  logic              wr0;
  logic              wr1;

  assign wr0 = we0 && !((ZERO_REG != 0) && (wa0 == '0));
  assign wr1 = we1 && !((ZERO_REG != 0) && (wa1 == '0));

  // Clears first so a same-cycle busy_set (new producer) wins.
  always_comb begin
    busy_nxt = busy;
    if (we0) busy_nxt[wa0] = 1'b0;
    if (we1) busy_nxt[wa1] = 1'b0;
    if (busy_set) busy_nxt[busy_addr] = 1'b1;
    if (ZERO_REG != 0) busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      busy <= '0;
    end else begin
      if (wr0) mem[wa0] <= wd0;
      if (wr1) mem[wa1] <= wd1;
      busy <= busy_nxt;
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] rdat;
    logic              rbsy;

    assign a = rd_addr[k*ADDR_W +: ADDR_W];

    // Port 1 checked last so it overrides port 0 on a collision.
    always_comb begin
      rdat = mem[a];
      rbsy = busy[a];
      if (we0 && (wa0 == a)) begin
        rdat = wd0;
        rbsy = 1'b0;
      end
      if (we1 && (wa1 == a)) begin
        rdat = wd1;
        rbsy = 1'b0;
      end
      if (rst || ((ZERO_REG != 0) && (a == '0))) begin
        rdat = '0;
        rbsy = 1'b0;
      end
    end

    assign rd_data[k*DATA_W +: DATA_W] = rdat;
    assign rd_busy[k]                  = rbsy;
  end

endmodule

// File: tb/tb_reg_file_bypass.sv
// Directed bench for reg_file_bypass: expected read results are queued as
// stimulus is driven and compared against the ports mid-cycle.
module tb_reg_file_bypass;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 2;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [NR*AW-1:0] rd_addr = '0;
  logic [NR*DW-1:0] rd_data;
  logic [NR-1:0]    rd_busy;
  logic             we0 = 1'b0;
  logic [AW-1:0]    wa0 = '0;
  logic [DW-1:0]    wd0 = '0;
  logic             we1 = 1'b0;
  logic [AW-1:0]    wa1 = '0;
  logic [DW-1:0]    wd1 = '0;
  logic             busy_set = 1'b0;
  logic [AW-1:0]    busy_addr = '0;

  int total  = 0;
  int passed = 0;

  typedef struct {
    string       tag;
    int          port;
    logic [31:0] d;
    logic        b;
  } exp_t;

  exp_t exp_q[$];

  reg_file_bypass #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .ZERO_REG(1)) dut (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .we0(we0), .wa0(wa0), .wd0(wd0), .we1(we1), .wa1(wa1), .wd1(wd1),
    .busy_set(busy_set), .busy_addr(busy_addr)
  );

  always #5 clk = ~clk;

  task automatic push_exp(input string tag, input int port, input logic [31:0] d, input logic b);
    exp_t e;
    e.tag = tag;
    e.port = port;
    e.d = d;
    e.b = b;
    exp_q.push_back(e);
  endtask

  task automatic sample();
    exp_t        e;
    logic [31:0] od;
    logic        ob;
    #1;
    while (exp_q.size() > 0) begin
      e  = exp_q.pop_front();
      od = rd_data[e.port*DW +: DW];
      ob = rd_busy[e.port];
      total++;
      assert (od === e.d) passed++;
      else $error("FAIL %s data p%0d: got %h expected %h", e.tag, e.port, od, e.d);
      total++;
      assert (ob === e.b) passed++;
      else $error("FAIL %s busy p%0d: got %b expected %b", e.tag, e.port, ob, e.b);
    end
  endtask

  task automatic next();
    @(negedge clk);
    we0 = 1'b0;
    we1 = 1'b0;
    busy_set = 1'b0;
  endtask

  task automatic set_rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    rd_addr = {a1, a0};
  endtask

  initial begin
    // Power-on reset state
    set_rd(5'd0, 5'd1);
    push_exp("por", 0, 32'h0, 1'b0);
    push_exp("por", 1, 32'h0, 1'b0);
    sample();
    next();
    rst = 1'b0;

    // Fill x1..x31, and mark x4 busy alongside the last write
    for (int i = 1; i < 32; i++) begin
      we0 = 1'b1;
      wa0 = AW'(i);
      wd0 = 32'hA5A5_0000 + i;
      if (i == 31) begin
        busy_set  = 1'b1;
        busy_addr = 5'd4;
      end
      next();
    end
    set_rd(5'd31, 5'd4);
    push_exp("fill", 0, 32'hA5A5_001F, 1'b0);
    push_exp("fill", 1, 32'hA5A5_0004, 1'b1);
    sample();

    // Asynchronous reset mid-cycle, with a write presented to x31
    #2 rst = 1'b1;
    we0 = 1'b1;
    wa0 = 5'd31;
    wd0 = 32'hDEAD_BEEF;
    push_exp("rst_async", 0, 32'h0, 1'b0);
    push_exp("rst_async", 1, 32'h0, 1'b0);
    sample();
    next();
    we1 = 1'b1;
    wa1 = 5'd4;
    wd1 = 32'h4444_4444;
    busy_set  = 1'b1;
    busy_addr = 5'd31;
    push_exp("rst_held", 0, 32'h0, 1'b0);
    push_exp("rst_held", 1, 32'h0, 1'b0);
    sample();
    next();
    rst = 1'b0;
    for (int a = 0; a < 32; a += 2) begin
      set_rd(AW'(a), AW'(a + 1));
      push_exp($sformatf("post_rst x%0d", a), 0, 32'h0, 1'b0);
      push_exp($sformatf("post_rst x%0d", a + 1), 1, 32'h0, 1'b0);
      sample();
      next();
    end

    // Same-cycle bypass then persistence
    we0 = 1'b1;
    wa0 = 5'd5;
    wd0 = 32'h1234_5678;
    set_rd(5'd5, 5'd6);
    push_exp("bypass", 0, 32'h1234_5678, 1'b0);
    push_exp("bypass_other", 1, 32'h0, 1'b0);
    sample();
    next();
    push_exp("persist", 0, 32'h1234_5678, 1'b0);
    sample();
    next();

    // Write collision on x7: port 1 wins
    we0 = 1'b1;
    wa0 = 5'd7;
    wd0 = 32'h0000_1111;
    we1 = 1'b1;
    wa1 = 5'd7;
    wd1 = 32'h0000_2222;
    set_rd(5'd7, 5'd7);
    push_exp("collide_byp", 0, 32'h0000_2222, 1'b0);
    push_exp("collide_byp", 1, 32'h0000_2222, 1'b0);
    sample();
    next();
    push_exp("collide_mem", 1, 32'h0000_2222, 1'b0);
    sample();
    next();

    // Independent writes on both ports to different registers
    we0 = 1'b1;
    wa0 = 5'd10;
    wd0 = 32'h0A0A_0A0A;
    we1 = 1'b1;
    wa1 = 5'd11;
    wd1 = 32'h0B0B_0B0B;
    set_rd(5'd10, 5'd11);
    push_exp("dual_byp", 0, 32'h0A0A_0A0A, 1'b0);
    push_exp("dual_byp", 1, 32'h0B0B_0B0B, 1'b0);
    sample();
    next();
    push_exp("dual_mem", 0, 32'h0A0A_0A0A, 1'b0);
    push_exp("dual_mem", 1, 32'h0B0B_0B0B, 1'b0);
    sample();
    next();

    // Zero register: write and busy_set to x0 are ignored
    we1 = 1'b1;
    wa1 = 5'd0;
    wd1 = 32'hFFFF_FFFF;
    busy_set  = 1'b1;
    busy_addr = 5'd0;
    set_rd(5'd0, 5'd0);
    push_exp("x0_same", 0, 32'h0, 1'b0);
    push_exp("x0_same", 1, 32'h0, 1'b0);
    sample();
    next();
    push_exp("x0_after", 0, 32'h0, 1'b0);
    push_exp("x0_after", 1, 32'h0, 1'b0);
    sample();
    next();

    // Scoreboard on x9: set in cycle 1, written by port 1 in cycle 5
    busy_set  = 1'b1;
    busy_addr = 5'd9;
    set_rd(5'd0, 5'd9);
    push_exp("sb_c1", 1, 32'h0, 1'b0);
    sample();
    for (int c = 2; c <= 4; c++) begin
      next();
      push_exp($sformatf("sb_c%0d", c), 1, 32'h0, 1'b1);
      sample();
    end
    next();
    we1 = 1'b1;
    wa1 = 5'd9;
    wd1 = 32'hCAFE_F00D;
    set_rd(5'd9, 5'd9);
    push_exp("sb_c5", 0, 32'hCAFE_F00D, 1'b0);
    push_exp("sb_c5", 1, 32'hCAFE_F00D, 1'b0);
    sample();
    next();
    push_exp("sb_c6", 1, 32'hCAFE_F00D, 1'b0);
    sample();
    next();

    // Port 0 write also clears busy
    busy_set  = 1'b1;
    busy_addr = 5'd12;
    next();
    set_rd(5'd12, 5'd0);
    push_exp("clr0_busy", 0, 32'h0, 1'b1);
    sample();
    next();
    we0 = 1'b1;
    wa0 = 5'd12;
    wd0 = 32'h0000_0C0C;
    push_exp("clr0_byp", 0, 32'h0000_0C0C, 1'b0);
    sample();
    next();
    push_exp("clr0_after", 0, 32'h0000_0C0C, 1'b0);
    sample();
    next();

    // Set/clear race on x3: set wins
    busy_set  = 1'b1;
    busy_addr = 5'd3;
    next();
    set_rd(5'd3, 5'd3);
    push_exp("race_pre", 0, 32'h0, 1'b1);
    sample();
    next();
    we0 = 1'b1;
    wa0 = 5'd3;
    wd0 = 32'h0000_0033;
    busy_set  = 1'b1;
    busy_addr = 5'd3;
    push_exp("race_same", 0, 32'h0000_0033, 1'b0);
    push_exp("race_same", 1, 32'h0000_0033, 1'b0);
    sample();
    next();
    push_exp("race_next", 0, 32'h0000_0033, 1'b1);
    push_exp("race_next", 1, 32'h0000_0033, 1'b1);
    sample();
    next();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
